// File: rtl/miriscv_gpr_pkg.sv
// General-purpose register file parameters.
package miriscv_gpr_pkg;

   localparam int GPR_ADDR_W = 5;

endpackage

// File: rtl/miriscv_pkg.sv
// Core-wide package: datapath width and pipeline control FSM states.
package miriscv_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } pipe_ctrl_state_e;

endpackage

// File: rtl/miriscv_raw_hazard_detect.sv
// Read-after-write hazard detector: compares the stage-0 source registers
// against the destinations of every older in-flight stage. Purely combinational.
module miriscv_raw_hazard_detect
   import miriscv_gpr_pkg::*;
#(
   parameter int NUM_STAGES = 5
) (
   input  logic [NUM_STAGES-1:0]                 valid_i,
   input  logic [NUM_STAGES-1:0]                 rd_we_i,
   input  logic [NUM_STAGES-1:0][GPR_ADDR_W-1:0] rd_addr_i,
   input  logic [GPR_ADDR_W-1:0]                 rs1_addr_i,
   input  logic [GPR_ADDR_W-1:0]                 rs2_addr_i,
   input  logic                                  rs1_req_i,
   input  logic                                  rs2_req_i,
   output logic                                  raw_o
);

   logic [NUM_STAGES-1:0] hit;

   // Stage 0 is the consumer itself, so it never produces a hit.
   assign hit[0] = 1'b0;

   genvar k;
   generate
      for (k = 1; k < NUM_STAGES; k++) begin : g_cmp
         // x0 is hard-wired zero, so a write to it is never a real producer.
         assign hit[k] = valid_i[k] & rd_we_i[k] & (rd_addr_i[k] != '0) &
                         ((rs1_req_i & (rs1_addr_i == rd_addr_i[k])) |
                          (rs2_req_i & (rs2_addr_i == rd_addr_i[k])));
      end
   endgenerate

   assign raw_o = valid_i[0] & (|hit);

   // Stage-0 destination fields carry no producer information here.
   logic unused_stage0;
   assign unused_stage0 = rd_we_i[0] ^ (^rd_addr_i[0]);

endmodule

// File: rtl/miriscv_pipe_ctrl.sv
// Pipeline control: per-stage stall/kill, fetch PC redirect, boot redirect
// and FENCE.I drain. Optional performance counters are built when
// MIRISCV_PIPE_CTRL_PERF_EN is defined.
module miriscv_pipe_ctrl
   import miriscv_pkg::*;
   import miriscv_gpr_pkg::*;
#(
   parameter int NUM_STAGES  = 5,
   parameter int BOOT_CYCLES = 2
) (
   input  logic                                  clk_i,
   input  logic                                  arstn_i,
   input  logic [XLEN-1:0]                       boot_addr_i,
   input  logic [NUM_STAGES-1:0]                 stall_req_i,
   input  logic [NUM_STAGES-1:0]                 valid_i,
   input  logic [GPR_ADDR_W-1:0]                 rs1_addr_i,
   input  logic [GPR_ADDR_W-1:0]                 rs2_addr_i,
   input  logic                                  rs1_req_i,
   input  logic                                  rs2_req_i,
   input  logic [NUM_STAGES-1:0][GPR_ADDR_W-1:0] rd_addr_i,
   input  logic [NUM_STAGES-1:0]                 rd_we_i,
   input  logic                                  fence_i_req_i,
   input  logic [XLEN-1:0]                       fence_next_pc_i,
   input  logic                                  res_prediction_i,
   input  logic                                  res_taken_i,
   input  logic [XLEN-1:0]                       res_target_pc_i,
   input  logic [XLEN-1:0]                       res_next_pc_i,
   output logic [NUM_STAGES-1:0]                 stall_o,
   output logic [NUM_STAGES-1:0]                 kill_o,
   output logic                                  force_o,
   output logic [XLEN-1:0]                       force_pc_o,
`ifdef MIRISCV_PIPE_CTRL_PERF_EN
   output logic [31:0]                           stall_cnt_o,
   output logic [31:0]                           mispred_cnt_o,
`endif
   output logic                                  fence_done_o
);

   localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

   pipe_ctrl_state_e      state_q;
   logic [3:0]            boot_cnt_q;
   logic [XLEN-1:0]       fence_pc_q;

   logic                  raw;
   logic                  mispredict;
   logic                  older_idle;
   logic                  drain_done;
   logic                  fence_start;
   logic [NUM_STAGES-1:0] stall_chain;

   miriscv_raw_hazard_detect #(
      .NUM_STAGES (NUM_STAGES)
   ) u_raw (
      .valid_i    (valid_i),
      .rd_we_i    (rd_we_i),
      .rd_addr_i  (rd_addr_i),
      .rs1_addr_i (rs1_addr_i),
      .rs2_addr_i (rs2_addr_i),
      .rs1_req_i  (rs1_req_i),
      .rs2_req_i  (rs2_req_i),
      .raw_o      (raw)
   );

   assign mispredict  = (state_q != BOOT) & valid_i[NUM_STAGES-1] &
                        (res_prediction_i ^ res_taken_i);
   assign older_idle  = ~(|valid_i[NUM_STAGES-1:1]);
   // A mispredict in DRAIN kills the fence, so it never completes that cycle.
   assign drain_done  = (state_q == DRAIN) & older_idle & ~mispredict;
   assign fence_start = valid_i[0] & fence_i_req_i & ~mispredict & ~raw;

   // A stall in a stage back-pressures every younger stage.
   always_comb begin
      stall_chain = '0;
      for (int i = 0; i < NUM_STAGES; i++)
         stall_chain[i] = |(stall_req_i >> i);
   end

   // Output mux; redirect priority is boot, then mispredict, then fence refetch.
   always_comb begin
      stall_o      = stall_chain;
      stall_o[0]   = stall_chain[0] | raw | (state_q == DRAIN);
      kill_o       = '0;
      force_o      = 1'b0;
      force_pc_o   = boot_addr_i;
      fence_done_o = 1'b0;
      if (state_q == BOOT) begin
         stall_o    = '0;
         force_o    = 1'b1;
         force_pc_o = boot_addr_i;
      end else if (mispredict) begin
         kill_o     = '1;
         force_o    = 1'b1;
         force_pc_o = res_taken_i ? res_target_pc_i : res_next_pc_i;
      end else if (drain_done) begin
         kill_o[0]    = 1'b1;
         force_o      = 1'b1;
         force_pc_o   = fence_pc_q;
         fence_done_o = 1'b1;
      end
   end

   // Control FSM: boot countdown, then run with FENCE.I drain excursions.
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         state_q    <= BOOT;
         boot_cnt_q <= '0;
         fence_pc_q <= '0;
      end else begin
         case (state_q)
            BOOT: begin
               boot_cnt_q <= boot_cnt_q + 4'd1;
               if (boot_cnt_q == BOOT_LAST) state_q <= RUN;
            end
            RUN: begin
               if (fence_start) begin
                  state_q    <= DRAIN;
                  fence_pc_q <= fence_next_pc_i;
               end
            end
            DRAIN: begin
               if (mispredict || older_idle) state_q <= RUN;
            end
            default: state_q <= BOOT;
         endcase
      end
   end

`ifdef MIRISCV_PIPE_CTRL_PERF_EN
   logic [31:0] stall_cnt_q;
   logic [31:0] mispred_cnt_q;

   // Event counters; they wrap naturally at 2^32.
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         stall_cnt_q   <= '0;
         mispred_cnt_q <= '0;
      end else begin
         if ((state_q != BOOT) && stall_o[0]) stall_cnt_q <= stall_cnt_q + 32'd1;
         if (mispredict) mispred_cnt_q <= mispred_cnt_q + 32'd1;
      end
   end

   assign stall_cnt_o   = stall_cnt_q;
   assign mispred_cnt_o = mispred_cnt_q;
`endif

endmodule

// File: tb/tb_miriscv_pipe_ctrl.sv
// Self-checking bench for miriscv_pipe_ctrl: directed scenarios followed by
// random traffic, all compared against a rule-level reference model.
module tb_miriscv_pipe_ctrl;

   localparam int NS = 5;
   localparam int BC = 3;

   logic                clk = 1'b0;
   logic                arstn;
   logic [31:0]         boot_addr;
   logic [NS-1:0]       stall_req, valid, rd_we;
   logic [4:0]          rs1, rs2;
   logic                rs1_req, rs2_req;
   logic [NS-1:0][4:0]  rd_addr;
   logic                fence_req;
   logic [31:0]         fence_next;
   logic                pred, taken;
   logic [31:0]         tgt_pc, nxt_pc;
   logic [NS-1:0]       stall, kill;
   logic                force_s;
   logic [31:0]         force_pc;
   logic                fence_done;
`ifdef MIRISCV_PIPE_CTRL_PERF_EN
   logic [31:0]         stall_cnt, mispred_cnt;
`endif

   int n_chk = 0;
   int n_err = 0;

   // reference model state
   int          boot_left;
   bit          m_drain;
   logic [31:0] m_fpc;
   logic [31:0] m_scnt, m_mcnt;

   always #5 clk = ~clk;

   miriscv_pipe_ctrl #(.NUM_STAGES(NS), .BOOT_CYCLES(BC)) dut (
      .clk_i            (clk),
      .arstn_i          (arstn),
      .boot_addr_i      (boot_addr),
      .stall_req_i      (stall_req),
      .valid_i          (valid),
      .rs1_addr_i       (rs1),
      .rs2_addr_i       (rs2),
      .rs1_req_i        (rs1_req),
      .rs2_req_i        (rs2_req),
      .rd_addr_i        (rd_addr),
      .rd_we_i          (rd_we),
      .fence_i_req_i    (fence_req),
      .fence_next_pc_i  (fence_next),
      .res_prediction_i (pred),
      .res_taken_i      (taken),
      .res_target_pc_i  (tgt_pc),
      .res_next_pc_i    (nxt_pc),
      .stall_o          (stall),
      .kill_o           (kill),
      .force_o          (force_s),
      .force_pc_o       (force_pc),
`ifdef MIRISCV_PIPE_CTRL_PERF_EN
      .stall_cnt_o      (stall_cnt),
      .mispred_cnt_o    (mispred_cnt),
`endif
      .fence_done_o     (fence_done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      boot_left = BC;
      m_drain   = 1'b0;
      m_fpc     = '0;
      m_scnt    = '0;
      m_mcnt    = '0;
   endtask

   task automatic idle();
      stall_req = '0; valid = '0; rd_we = '0; rd_addr = '0;
      rs1 = '0; rs2 = '0; rs1_req = 1'b0; rs2_req = 1'b0;
      fence_req = 1'b0; fence_next = '0;
      pred = 1'b0; taken = 1'b0; tgt_pc = '0; nxt_pc = '0;
   endtask

   // One cycle: check outputs mid-cycle against the rules, then advance the model.
   task automatic step(input string tag);
      logic          raw, mis, done, e_force;
      logic [NS-1:0] e_stall, e_kill;
      logic [31:0]   e_pc;
      @(negedge clk); #1;
      if (!arstn) model_reset();
      raw = 1'b0;
      for (int k = 1; k < NS; k++)
         if (valid[k] && rd_we[k] && rd_addr[k] != 0 &&
             ((rs1_req && rs1 == rd_addr[k]) || (rs2_req && rs2 == rd_addr[k])))
            raw = 1'b1;
      raw  = raw & valid[0];
      mis  = (boot_left == 0) && valid[NS-1] && (pred != taken);
      done = m_drain && (valid[NS-1:1] == 0) && !mis;
      e_stall = '0; e_kill = '0; e_force = 1'b0; e_pc = '0;
      if (boot_left > 0) begin
         e_force = 1'b1; e_pc = boot_addr;
      end else begin
         for (int i = 0; i < NS; i++) e_stall[i] = ((stall_req >> i) != 0);
         e_stall[0] = e_stall[0] | raw | m_drain;
         if (mis) begin
            e_kill = '1; e_force = 1'b1; e_pc = taken ? tgt_pc : nxt_pc;
         end else if (done) begin
            e_kill = 1; e_force = 1'b1; e_pc = m_fpc;
         end
      end
      chk({tag, ".stall"}, 32'(stall), 32'(e_stall));
      chk({tag, ".kill"},  32'(kill),  32'(e_kill));
      chk({tag, ".force"}, 32'(force_s), 32'(e_force));
      if (e_force) chk({tag, ".pc"}, force_pc, e_pc);
      chk({tag, ".done"},  32'(fence_done), 32'(done && boot_left == 0));
`ifdef MIRISCV_PIPE_CTRL_PERF_EN
      chk({tag, ".scnt"}, stall_cnt, m_scnt);
      chk({tag, ".mcnt"}, mispred_cnt, m_mcnt);
`endif
      @(posedge clk); #1;
      if (!arstn) begin
         model_reset();
      end else if (boot_left > 0) begin
         boot_left--;
      end else begin
         if (e_stall[0]) m_scnt++;
         if (mis) begin
            m_mcnt++;
            m_drain = 1'b0;
         end else if (m_drain) begin
            if (done) m_drain = 1'b0;
         end else if (valid[0] && fence_req && !raw) begin
            m_drain = 1'b1;
            m_fpc   = fence_next;
         end
      end
   endtask

   initial begin
      idle();
      model_reset();
      arstn = 1'b0;
      boot_addr = 32'h8000_0000;
      step("rst"); step("rst");
      #1 arstn = 1'b1;
      // boot redirect for BC cycles, then released
      for (int i = 0; i < BC + 1; i++) step("boot");

      // RAW hazard from stage 2 on x5, then the same with x0
      valid = 5'b00101; rs1 = 5'd5; rs1_req = 1'b1;
      rd_addr[2] = 5'd5; rd_we[2] = 1'b1;
      step("raw_x5");
      rd_addr[2] = 5'd0; rs1 = 5'd0;
      step("raw_x0");
      idle();

      // mispredict in resolve stage
      valid = 5'b10000; pred = 1'b0; taken = 1'b1; tgt_pc = 32'h100;
      step("mispred");
      idle(); step("idle");

      // FENCE.I drain over 4 cycles
      valid = 5'b11111; fence_req = 1'b1; fence_next = 32'h204;
      step("fence_go");
      fence_req = 1'b0; fence_next = 32'h0;
      valid = 5'b11110; step("drain1");
      valid = 5'b11100; step("drain2");
      valid = 5'b11000; step("drain3");
      valid = 5'b00001; step("drain_done");
      idle(); step("after_fence");

      // mispredict during DRAIN kills the fence
      valid = 5'b00001; fence_req = 1'b1; fence_next = 32'h208;
      step("fence_go2");
      idle();
      valid = 5'b10000; pred = 1'b1; taken = 1'b0; nxt_pc = 32'h300;
      step("drain_mispred");
      idle(); step("back_run");

      // stall request in stage 3
      stall_req = 5'b01000; step("stall3");
      idle();

      // reset in the middle of a drain
      valid = 5'b00011; fence_req = 1'b1; fence_next = 32'h400;
      step("fence_go3");
      idle(); valid = 5'b00010;
      #1 arstn = 1'b0;
      step("rst_drain");
      #1 arstn = 1'b1;
      idle();
      for (int i = 0; i < BC + 1; i++) step("reboot");

      // random traffic
      for (int n = 0; n < 600; n++) begin
         arstn     = ($urandom_range(0, 99) != 0);
         boot_addr = $urandom;
         for (int s = 0; s < NS; s++) begin
            valid[s]   = (s == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) < 3);
            rd_we[s]   = $urandom_range(0, 1);
            rd_addr[s] = 5'($urandom_range(0, 3));
         end
         stall_req  = ($urandom_range(0, 7) == 0) ? NS'($urandom) : '0;
         rs1        = 5'($urandom_range(0, 3));
         rs2        = 5'($urandom_range(0, 3));
         rs1_req    = $urandom_range(0, 1);
         rs2_req    = $urandom_range(0, 1);
         fence_req  = ($urandom_range(0, 3) == 0);
         fence_next = $urandom;
         pred       = $urandom_range(0, 1);
         taken      = ($urandom_range(0, 2) == 0) ? ~pred : pred;
         tgt_pc     = $urandom;
         nxt_pc     = $urandom;
         step("rand");
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
